// File: rtl/noc_sink_checker_pkg.sv
// Shared definitions for the NoC sink checker: header layout, FSM states,
// error-flag bit positions and small helpers used by the checker datapath.
package noc_sink_checker_pkg;

  localparam logic [7:0] PAYLOAD_MARK = 8'hA5;

  localparam int ERR_MISROUTE = 0;
  localparam int ERR_NO_HDR   = 1;
  localparam int ERR_HDR_MID  = 2;
  localparam int ERR_LEN      = 3;
  localparam int ERR_PAYLOAD  = 4;
  localparam int ERR_SEQ      = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DRAIN
  } state_t;

  // Field order mirrors the header bit layout, MSB first.
  typedef struct packed {
    logic [7:0] len;
    logic [7:0] seq;
    logic [3:0] src_y;
    logic [3:0] src_x;
    logic [3:0] dest_y;
    logic [3:0] dest_x;
  } header_t;

  function automatic logic [31:0] payload_word(input logic [7:0] seq, input logic [7:0] idx);
    return {PAYLOAD_MARK, seq, 8'h00, idx};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/noc_seq_table.sv
// Per-source expected-sequence register file: combinational read, one
// synchronous write port, cleared by the asynchronous reset.
module noc_seq_table #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             noc_clk,
  input  logic             noc_rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data
);

  logic [7:0] mem [DEPTH];

  assign rd_data = ({1'b0, rd_idx} < (IDX_W+1)'(DEPTH)) ? mem[rd_idx] : 8'h00;

  // NOTE: this storage is reset on purpose: every source must start by
  // expecting seq 0, so it is built from resettable flops, not a RAM macro.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/noc_sink_checker.sv
// Receive endpoint for the mesh: accepts wormhole packets on a valid/ready
// port and checks routing, sequence, length and payload pattern per packet.
module noc_sink_checker
  import noc_sink_checker_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int X_ID         = 0,
  parameter int Y_ID         = 0,
  parameter int MESH_X       = 2,
  parameter int MESH_Y       = 2,
  parameter int STALL_PERIOD = 0
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              receive_valid,
  output logic              receive_ready,
  input  logic [DATA_W-1:0] receive_flit,
  input  logic              receive_is_header,
  input  logic              receive_is_tail,
  output logic [7:0]        receive_num,
  output logic [7:0]        err_count,
  output logic [5:0]        err_flags,
  output logic              busy
);

  localparam int NUM_SRC = MESH_X * MESH_Y;
  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t      state, state_n;
  logic [7:0]  idx, idx_n;
  logic [7:0]  cur_seq, seq_n;
  logic [7:0]  cur_len, len_n;
  logic        pkt_err, pkt_err_n;
  logic [5:0]  flags_n;
  logic [7:0]  num_n, errc_n;
  logic [5:0]  new_err;
  logic        done;
  logic        accept;
  logic        hi_zero;
  header_t     hdr;
  logic [31:0] src_idx;
  logic        src_ok;
  logic [7:0]  exp_seq;
  logic        wr_en;

  // Backpressure generator: ready drops for one cycle every STALL_PERIOD.
  if (STALL_PERIOD == 0) begin : g_no_stall
    assign receive_ready = 1'b1;
  end else begin : g_stall
    localparam int CNT_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_PERIOD - 1);
    logic [CNT_W-1:0] stall_cnt, stall_cnt_n;
    logic             ready_q;

    assign stall_cnt_n = (stall_cnt == CNT_LAST) ? '0 : stall_cnt + CNT_W'(1);

    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
        stall_cnt <= '0;
        ready_q   <= 1'b1;
      end else begin
        stall_cnt <= stall_cnt_n;
        ready_q   <= (stall_cnt_n != CNT_LAST);
      end
    end

    assign receive_ready = ready_q;
  end

  if (DATA_W > 32) begin : g_wide
    assign hi_zero = ~|receive_flit[DATA_W-1:32];
  end else begin : g_narrow
    assign hi_zero = 1'b1;
  end

  assign accept  = receive_valid && receive_ready;
  assign hdr     = header_t'(receive_flit[31:0]);
  assign src_idx = {28'd0, hdr.src_y} * 32'(MESH_X) + {28'd0, hdr.src_x};
  assign src_ok  = (src_idx < 32'(NUM_SRC));

  noc_seq_table #(
    .DEPTH (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_seq_table (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .rd_idx    (src_idx[IDX_W-1:0]),
    .rd_data   (exp_seq),
    .wr_en     (wr_en),
    .wr_idx    (src_idx[IDX_W-1:0]),
    .wr_data   (hdr.seq + 8'd1)
  );

  always_comb begin
    // NOTE: every signal driven here is defaulted first, so no path can
    // leave one unassigned and infer a latch.
    state_n = state;
    idx_n   = idx;
    seq_n   = cur_seq;
    len_n   = cur_len;
    new_err = '0;
    done    = 1'b0;
    wr_en   = 1'b0;

    if (accept) begin
      unique case (state)
        ST_IDLE: begin
          if (!receive_is_header) begin
            new_err[ERR_NO_HDR] = 1'b1;
            done                = receive_is_tail;
            if (!receive_is_tail) state_n = ST_DRAIN;
          end else begin
            seq_n = hdr.seq;
            len_n = hdr.len;
            wr_en = src_ok;
            if (hdr.dest_x != 4'(X_ID) || hdr.dest_y != 4'(Y_ID) || !src_ok)
              new_err[ERR_MISROUTE] = 1'b1;
            if (src_ok && hdr.seq != exp_seq) new_err[ERR_SEQ] = 1'b1;
            if (receive_is_tail) begin
              if (hdr.len != 8'd0) new_err[ERR_LEN] = 1'b1;
              done = 1'b1;
            end else begin
              state_n = ST_PAYLOAD;
              idx_n   = 8'd0;
            end
          end
        end

        ST_PAYLOAD: begin
          if (receive_flit[31:0] != payload_word(cur_seq, idx) || !hi_zero)
            new_err[ERR_PAYLOAD] = 1'b1;
          if (receive_is_header) new_err[ERR_HDR_MID] = 1'b1;
          idx_n = idx + 8'd1;
          // Compare in 9 bits so len=255 never wraps the flit count.
          if (receive_is_tail) begin
            if (({1'b0, idx} + 9'd1) != {1'b0, cur_len}) new_err[ERR_LEN] = 1'b1;
            done    = 1'b1;
            state_n = ST_IDLE;
          end else if (({1'b0, idx} + 9'd1) >= {1'b0, cur_len}) begin
            new_err[ERR_LEN] = 1'b1;
            state_n          = ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (receive_is_tail) begin
            done    = 1'b1;
            state_n = ST_IDLE;
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end

    pkt_err_n = ((state == ST_IDLE) ? 1'b0 : pkt_err) | (|new_err);
    flags_n   = err_flags | new_err;
    num_n     = receive_num;
    errc_n    = err_count;
    if (done) begin
      if (pkt_err_n) errc_n = sat_inc(err_count);
      else           num_n  = sat_inc(receive_num);
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state       <= ST_IDLE;
      idx         <= 8'd0;
      cur_seq     <= 8'd0;
      cur_len     <= 8'd0;
      pkt_err     <= 1'b0;
      err_flags   <= 6'd0;
      receive_num <= 8'd0;
      err_count   <= 8'd0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cur_seq     <= seq_n;
      cur_len     <= len_n;
      pkt_err     <= pkt_err_n;
      err_flags   <= flags_n;
      receive_num <= num_n;
      err_count   <= errc_n;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_noc_sink_checker.sv
// Self-checking bench for noc_sink_checker: directed and random packets
// compared against a packet-level reference model of the checking rules.
module tb_noc_sink_checker;

  localparam int MX = 2;
  localparam int MY = 2;
  localparam int XI = 1;
  localparam int YI = 1;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        is_hdr = 1'b0;
  logic        is_tail = 1'b0;
  logic [31:0] flit = '0;
  bit          sel = 1'b0;

  logic       valid0, valid1, ready0, ready1, busy0, busy1;
  logic [7:0] num0, num1, errc0, errc1;
  logic [5:0] flags0, flags1;
  logic       rdy, busy;
  logic [7:0] num, errc;
  logic [5:0] flags;

  assign valid0 = valid & ~sel;
  assign valid1 = valid & sel;
  assign rdy    = sel ? ready1 : ready0;
  assign busy   = sel ? busy1  : busy0;
  assign num    = sel ? num1   : num0;
  assign errc   = sel ? errc1  : errc0;
  assign flags  = sel ? flags1 : flags0;

  always #5 noc_clk = ~noc_clk;

  noc_sink_checker #(.DATA_W(32), .X_ID(XI), .Y_ID(YI), .MESH_X(MX), .MESH_Y(MY),
                     .STALL_PERIOD(0)) dut0 (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .receive_valid(valid0),
    .receive_ready(ready0), .receive_flit(flit), .receive_is_header(is_hdr),
    .receive_is_tail(is_tail), .receive_num(num0), .err_count(errc0),
    .err_flags(flags0), .busy(busy0));

  noc_sink_checker #(.DATA_W(32), .X_ID(XI), .Y_ID(YI), .MESH_X(MX), .MESH_Y(MY),
                     .STALL_PERIOD(4)) dut1 (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .receive_valid(valid1),
    .receive_ready(ready1), .receive_flit(flit), .receive_is_header(is_hdr),
    .receive_is_tail(is_tail), .receive_num(num1), .err_count(errc1),
    .err_flags(flags1), .busy(busy1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the stream is cut at tail flits, each cut is one packet.
  typedef struct {
    logic [31:0] data;
    bit          h;
    bit          t;
  } flit_t;

  flit_t      frame[$];
  int         m_num, m_errc;
  logic [5:0] m_flags;
  logic [7:0] m_exp[MX*MY];

  function automatic void model_reset();
    frame.delete();
    m_num = 0;
    m_errc = 0;
    m_flags = '0;
    for (int i = 0; i < MX*MY; i++) m_exp[i] = 8'd0;
  endfunction

  function automatic void model_frame();
    logic [5:0]  e;
    logic [31:0] hd;
    logic [7:0]  seq, len;
    int          src, n, lim, chk;
    e = '0;
    if (!frame[0].h) begin
      e[1] = 1'b1;
    end else begin
      hd  = frame[0].data;
      seq = hd[23:16];
      len = hd[31:24];
      src = int'(hd[15:12]) * MX + int'(hd[11:8]);
      if (int'(hd[3:0]) != XI || int'(hd[7:4]) != YI || src >= MX*MY) e[0] = 1'b1;
      if (src < MX*MY) begin
        if (seq != m_exp[src]) e[5] = 1'b1;
        m_exp[src] = seq + 8'd1;
      end
      n = frame.size() - 1;
      if (n != int'(len)) e[3] = 1'b1;
      lim = (len == 8'd0) ? 1 : int'(len);
      chk = (n < lim) ? n : lim;
      for (int i = 0; i < chk; i++) begin
        if (frame[i+1].data !== {8'hA5, seq, 16'(i)}) e[4] = 1'b1;
        if (frame[i+1].h) e[2] = 1'b1;
      end
    end
    m_flags |= e;
    if (e != 6'd0) begin
      if (m_errc < 255) m_errc++;
    end else if (m_num < 255) begin
      m_num++;
    end
    frame.delete();
  endfunction

  function automatic void model_flit(input logic [31:0] d, input bit h, input bit t);
    frame.push_back('{data: d, h: h, t: t});
    if (t) model_frame();
  endfunction

  task automatic send_flit(input logic [31:0] d, input bit h, input bit t);
    bit done;
    done = 1'b0;
    @(negedge noc_clk);
    valid = 1'b1; flit = d; is_hdr = h; is_tail = t;
    for (int c = 0; c < 20 && !done; c++) begin
      if (rdy) begin
        @(posedge noc_clk);
        done = 1'b1;
      end else begin
        @(negedge noc_clk);
      end
    end
    if (!done) check("accept_timeout", 32'(rdy), 32'd1);
    else model_flit(d, h, t);
  endtask

  task automatic idle();
    @(negedge noc_clk);
    valid = 1'b0; is_hdr = 1'b0; is_tail = 1'b0;
  endtask

  task automatic send_pkt(input int dx, input int dy, input int sx, input int sy,
                          input logic [7:0] seq, input logic [7:0] len, input int n_pl,
                          input int bad_at = -1, input int hdrmid_at = -1);
    logic [31:0] d;
    send_flit({len, seq, 4'(sy), 4'(sx), 4'(dy), 4'(dx)}, 1'b1, n_pl == 0);
    for (int i = 0; i < n_pl; i++) begin
      d = {8'hA5, seq, 16'(i)};
      if (i == bad_at) d = d ^ 32'h0000_0100;
      send_flit(d, i == hdrmid_at, i == n_pl - 1);
    end
    idle();
  endtask

  task automatic check_all(input string tag);
    check({tag, "_num"},   32'(num),   32'(m_num));
    check({tag, "_errc"},  32'(errc),  32'(m_errc));
    check({tag, "_flags"}, 32'(flags), 32'(m_flags));
    check({tag, "_busy"},  32'(busy),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge noc_clk);
    valid = 1'b0;
    noc_rst_n = 1'b0;
    #1;
    check("rst_num",   32'(num),   32'd0);
    check("rst_errc",  32'(errc),  32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_ready", 32'(rdy),   32'd1);
    repeat (2) @(negedge noc_clk);
    noc_rst_n = 1'b1;
    model_reset();
  endtask

  // Ready monitor for the stalling instance.
  bit mon_en = 1'b0;
  int cyc = 0;
  int lows[$];
  always @(negedge noc_clk) begin
    if (mon_en) begin
      if (!ready1) lows.push_back(cyc);
      cyc++;
    end
  end

  initial begin
    int         sx, sy, src, n;
    logic [7:0] seq, len;

    model_reset();
    do_reset();
    check_all("reset");

    send_pkt(1, 1, 0, 0, 8'd0, 8'd3, 3);
    check_all("good_first");
    check("good_first_num_is_1", 32'(num), 32'd1);

    send_pkt(1, 1, 0, 0, 8'd5, 8'd2, 2);
    check_all("seq_gap");
    send_pkt(1, 1, 0, 0, 8'd6, 8'd2, 2);
    check_all("seq_resync");

    send_pkt(0, 1, 1, 0, 8'd0, 8'd0, 0);
    check_all("misroute_hdr_tail");

    send_pkt(1, 1, 1, 1, 8'd0, 8'd4, 2);
    check_all("short_tail");
    send_pkt(1, 1, 1, 1, 8'd1, 8'd1, 3);
    check_all("drain_long");

    send_flit(32'hA500_0000, 1'b0, 1'b0);
    send_flit(32'hA500_0001, 1'b0, 1'b1);
    idle();
    check_all("no_header");
    send_pkt(1, 1, 0, 1, 8'd0, 8'd2, 2);
    check_all("after_no_header");

    send_pkt(1, 1, 0, 1, 8'd1, 8'd3, 3, 1);
    check_all("payload_corrupt");
    send_pkt(1, 1, 0, 1, 8'd2, 8'd3, 3, -1, 2);
    check_all("hdr_mid");
    send_pkt(1, 1, 0, 2, 8'd0, 8'd1, 1);
    check_all("src_out_of_range");

    send_pkt(1, 1, 1, 0, 8'd1, 8'd255, 255);
    check_all("len_255");

    for (int k = 0; k < 16; k++) begin
      sx  = $urandom_range(0, 1);
      sy  = $urandom_range(0, 1);
      src = sy * MX + sx;
      seq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_exp[src];
      len = 8'($urandom_range(0, 6));
      n   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : int'(len);
      send_pkt(($urandom_range(0, 5) == 0) ? 0 : XI, YI, sx, sy, seq, len, n);
      check_all("random");
    end

    for (int k = 0; k < 260; k++) send_flit({24'd0, 8'h10}, 1'b1, 1'b1);
    idle();
    check_all("errc_saturate");
    check("errc_saturate_255", 32'(errc), 32'd255);

    send_flit({8'd5, 8'd0, 16'h0011}, 1'b1, 1'b0);
    send_flit(32'hA500_0000, 1'b0, 1'b0);
    send_flit(32'hA500_0001, 1'b0, 1'b0);
    idle();
    check("mid_pkt_busy", 32'(busy), 32'd1);
    do_reset();
    check_all("after_mid_reset");
    send_pkt(1, 1, 1, 1, 8'd0, 8'd2, 2);
    check_all("clean_after_reset");
    check("clean_after_reset_num_is_1", 32'(num), 32'd1);

    sel = 1'b1;
    do_reset();
    mon_en = 1'b1;
    send_pkt(1, 1, 0, 0, 8'd0, 8'd20, 20);
    mon_en = 1'b0;
    check_all("stall_pkt");
    check("stall_num_is_1", 32'(num), 32'd1);
    check("stall_lows_seen", 32'(lows.size() >= 5), 32'd1);
    for (int i = 1; i < lows.size(); i++)
      check("stall_gap", 32'(lows[i] - lows[i-1]), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
